uart_rx_fifo: RTL

- Synthesizable 8N1 UART receiver with a first-word-fall-through receive FIFO.
- Sits directly downstream of a UART TX pin (e.g. RsTx_Sys0_SS0_S0). It deserializes the serial stream into bytes.
- Used as an on-chip RX peripheral and as a synthesizable replacement for the behavioural bench terminal.
- Reports overrun and framing errors as sticky flags.

---
 rtl/uart_rx_fifo_if.sv | 39 +++
 rtl/uart_rx_fifo.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Bus bundle for uart_rx_fifo: serial input, FIFO pop port, status flags.
// Parity ports exist only when UART_RX_PARITY_EN is defined.
interface uart_rx_fifo_if #(
   parameter int AW = 4
) ();
   logic          en;
   logic [15:0]   prescale;
   logic          rx;
   logic          rd;
   logic [7:0]    rdata;
   logic          rvalid;
   logic [AW:0]   level;
   logic          clr;
   logic          overrun;
   logic          frame_err;
`ifdef UART_RX_PARITY_EN
   logic          parity_en;
   logic          parity_odd;
   logic          parity_err;

   modport master (
      output en, prescale, rx, rd, clr, parity_en, parity_odd,
      input  rdata, rvalid, level, overrun, frame_err, parity_err
   );
   modport slave (
      input  en, prescale, rx, rd, clr, parity_en, parity_odd,
      output rdata, rvalid, level, overrun, frame_err, parity_err
   );
`else
   modport master (
      output en, prescale, rx, rd, clr,
      input  rdata, rvalid, level, overrun, frame_err
   );
   modport slave (
      input  en, prescale, rx, rd, clr,
      output rdata, rvalid, level, overrun, frame_err
   );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (16x oversampling) feeding a first-word-fall-through FIFO.
// Define UART_RX_PARITY_EN to add an optional parity bit check with sticky parity_err.
module uart_rx_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   uart_rx_fifo_if.slave bus
);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_DATA    = 3'd2,
      S_STOP    = 3'd3,
      S_WAIT_HI = 3'd4,
      S_PARITY  = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_DATA    = 3'd2,
      S_STOP    = 3'd3,
      S_WAIT_HI = 3'd4
   } state_t;
`endif

   localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);

   function automatic logic parity_calc(input logic [7:0] data, input logic odd);
      parity_calc = (^data) ^ odd;
   endfunction

   logic [1:0]    sync_q, sync_d;
   logic          rx_s;
   logic [15:0]   pcnt_q, pcnt_d;
   logic          tick_s;
   state_t        state_q, state_d, after_data_s;
   logic [3:0]    tcnt_q, tcnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          push_s, ferr_set_s;
   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]   level_q, level_d;
   logic          pop_s, full_s, push_ok_s, ovr_set_s;
   logic          ovr_q, ovr_d, ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic          perr_set_s, perr_q, perr_d;
`endif

   assign rx_s = sync_q[1];

   // Oversample tick generator, held in phase reset until a start edge arrives
   always_comb begin
      sync_d = {sync_q[0], bus.rx};
      tick_s = 1'b0;
      pcnt_d = pcnt_q;
      if (!bus.en || state_q == S_IDLE) begin
         pcnt_d = 16'd0;
      end else if (pcnt_q == bus.prescale) begin
         tick_s = 1'b1;
         pcnt_d = 16'd0;
      end else begin
         pcnt_d = pcnt_q + 16'd1;
      end
   end

`ifdef UART_RX_PARITY_EN
   assign after_data_s = bus.parity_en ? S_PARITY : S_STOP;
`else
   assign after_data_s = S_STOP;
`endif

   // Frame decoder next-state logic
   always_comb begin
      state_d    = state_q;
      tcnt_d     = tcnt_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      push_s     = 1'b0;
      ferr_set_s = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_set_s = 1'b0;
`endif
      if (!bus.en) begin
         state_d = S_IDLE;
         tcnt_d  = 4'd0;
         bit_d   = 3'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               tcnt_d  = 4'd0;
               bit_d   = 3'd0;
               state_d = rx_s ? S_IDLE : S_START;
            end
            S_START: begin
               if (tick_s && tcnt_q == 4'd7) begin
                  tcnt_d  = 4'd0;
                  state_d = rx_s ? S_IDLE : S_DATA;
               end else if (tick_s) begin
                  tcnt_d = tcnt_q + 4'd1;
               end else begin
                  tcnt_d = tcnt_q;
               end
            end
            // tcnt wraps 15->0 on its own, so each 16th tick lands mid-bit
            S_DATA: begin
               if (tick_s) begin
                  tcnt_d = tcnt_q + 4'd1;
                  if (tcnt_q == 4'd15) begin
                     shift_d[bit_q] = rx_s;
                     bit_d          = bit_q + 3'd1;
                     state_d        = (bit_q == 3'd7) ? after_data_s : S_DATA;
                  end else begin
                     state_d = S_DATA;
                  end
               end else begin
                  tcnt_d = tcnt_q;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (tick_s) begin
                  tcnt_d = tcnt_q + 4'd1;
                  if (tcnt_q == 4'd15) begin
                     perr_set_s = (rx_s != parity_calc(shift_q, bus.parity_odd));
                     state_d    = S_STOP;
                  end else begin
                     state_d = S_PARITY;
                  end
               end else begin
                  tcnt_d = tcnt_q;
               end
            end
`endif
            S_STOP: begin
               if (tick_s) begin
                  tcnt_d = tcnt_q + 4'd1;
                  if (tcnt_q == 4'd15 && rx_s) begin
                     push_s  = 1'b1;
                     state_d = S_IDLE;
                  end else if (tcnt_q == 4'd15) begin
                     ferr_set_s = 1'b1;
                     state_d    = S_WAIT_HI;
                  end else begin
                     state_d = S_STOP;
                  end
               end else begin
                  tcnt_d = tcnt_q;
               end
            end
            // Line must return high before a new start bit is accepted (break filter)
            S_WAIT_HI: begin
               tcnt_d  = 4'd0;
               state_d = rx_s ? S_IDLE : S_WAIT_HI;
            end
            default: begin
               state_d = S_IDLE;
               tcnt_d  = 4'd0;
               bit_d   = 3'd0;
            end
         endcase
      end
   end

   // FIFO pointers, occupancy and sticky flags
   always_comb begin
      mem_d     = mem_q;
      pop_s     = bus.rd && (level_q != {(AW+1){1'b0}});
      full_s    = (level_q == FULL_LEVEL);
      push_ok_s = push_s && (!full_s || pop_s);
      ovr_set_s = push_s && full_s && !pop_s;
      wptr_d    = push_ok_s ? (wptr_q + PTR_ONE) : wptr_q;
      rptr_d    = pop_s ? (rptr_q + PTR_ONE) : rptr_q;
      if (push_ok_s) begin
         mem_d[wptr_q] = shift_q;
      end else begin
         mem_d[wptr_q] = mem_q[wptr_q];
      end
      case ({push_ok_s, pop_s})
         2'b10:   level_d = level_q + LEVEL_ONE;
         2'b01:   level_d = level_q - LEVEL_ONE;
         default: level_d = level_q;
      endcase
      ovr_d  = ovr_set_s  ? 1'b1 : (bus.clr ? 1'b0 : ovr_q);
      ferr_d = ferr_set_s ? 1'b1 : (bus.clr ? 1'b0 : ferr_q);
`ifdef UART_RX_PARITY_EN
      perr_d = perr_set_s ? 1'b1 : (bus.clr ? 1'b0 : perr_q);
`endif
   end

   // Receiver state registers
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         sync_q  <= 2'b11;
         pcnt_q  <= 16'd0;
         state_q <= S_IDLE;
         tcnt_q  <= 4'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
      end else begin
         sync_q  <= sync_d;
         pcnt_q  <= pcnt_d;
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   // FIFO storage and status registers
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
         wptr_q  <= {AW{1'b0}};
         rptr_q  <= {AW{1'b0}};
         level_q <= {(AW+1){1'b0}};
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   assign bus.rdata     = mem_q[rptr_q];
   assign bus.rvalid    = (level_q != {(AW+1){1'b0}});
   assign bus.level     = level_q;
   assign bus.overrun   = ovr_q;
   assign bus.frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err = perr_q;
`endif

endmodule
